// File: rtl/serial_add_pkg.sv
// Shared types and constants for the word-level serial adder front end.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CARRY = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int   DEF_WIDTH     = 8;
   localparam logic ADDER_CLR_RST = 1'b1;

endpackage

// File: rtl/serial_add_ctrl.sv
// Parallel-to-serial front end: feeds an external bit-serial adder LSB-first,
// gathers the sum bits and final carry, and returns the parallel result.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             a_bit,
   output logic             b_bit,
   output logic             cin_bit,
   output logic             adder_clr,
   input  logic             s_bit,
   input  logic             c_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output state_t           state
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           nxt;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sum_r;
   logic             cin_r;
   logic             cout_r;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= IDLE;
      else      state <= nxt;
   end

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and the result is held until taken.
   always_comb begin
      nxt       = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      adder_clr = ADDER_CLR_RST;
      a_bit     = 1'b0;
      b_bit     = 1'b0;
      cin_bit   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) nxt = SHIFT;
         end
         SHIFT: begin
            adder_clr = 1'b0;
            a_bit     = areg[0];
            b_bit     = breg[0];
            cin_bit   = (cnt == '0) ? cin_r : 1'b0;
            if (cnt == LAST) nxt = CARRY;
         end
         CARRY: begin
            adder_clr = 1'b0;
            nxt       = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // sum/cout live in their own registers so they hold across the next word's shifting.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         areg   <= '0;
         breg   <= '0;
         sreg   <= '0;
         sum_r  <= '0;
         cin_r  <= 1'b0;
         cout_r <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  areg  <= op_a;
                  breg  <= op_b;
                  cin_r <= cin;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               areg <= areg >> 1;
               breg <= breg >> 1;
               sreg <= {s_bit, sreg[WIDTH-1:1]};
               cnt  <= cnt + 1'b1;
            end
            CARRY: begin
               cout_r <= c_bit;
               sum_r  <= sreg;
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_r;
   assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised bench for serial_add_ctrl paired with a behavioural
// bit-serial adder; results go through an expected-value queue.
module tb_serial_add_ctrl;
   import serial_add_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         clr = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         cin = 1'b0;
   logic         a_bit, b_bit, cin_bit, adder_clr;
   logic         s_bit, c_bit;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   state_t       state;

   int n_checks = 0;
   int n_errors = 0;
   int n_out    = 0;
   logic [W:0] exp_q[$];
   time        out_t[$];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .cin(cin),
      .a_bit(a_bit), .b_bit(b_bit), .cin_bit(cin_bit), .adder_clr(adder_clr),
      .s_bit(s_bit), .c_bit(c_bit),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
      .state(state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // behavioural serial adder: registered carry, combinational sum
   logic carry_q;
   logic ci;
   assign ci    = carry_q ^ cin_bit;
   assign s_bit = a_bit ^ b_bit ^ ci;
   assign c_bit = carry_q;
   always @(posedge clk or negedge clr) begin
      if (!clr)           carry_q <= 1'b0;
      else if (adder_clr) carry_q <= 1'b0;
      else                carry_q <= (a_bit & b_bit) | (a_bit & ci) | (b_bit & ci);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // scoreboard: push reference on input transfer, compare on output transfer
   always @(negedge clk) begin
      if (clr && in_valid && in_ready)
         exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin});
      if (clr && out_valid && out_ready) begin
         n_out++;
         out_t.push_back($time);
         check("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (exp_q.size() > 0) check("sb_result", {cout, sum}, exp_q.pop_front());
      end
   end

   // driver tasks
   task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic keep);
      bit done = 0;
      op_a = a; op_b = b; cin = c; in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            if (!keep) in_valid = 1'b0;
            done = 1;
         end
      end
      check("accept_timeout", done, 1);
   endtask

   task automatic measure(output int lat, output int clr_lo, output int cin_hi,
                          output int cin_first);
      lat = 0; clr_lo = 0; cin_hi = 0; cin_first = 0;
      while (!out_valid && lat < 50) begin
         if (!adder_clr) clr_lo++;
         if (cin_bit) begin
            cin_hi++;
            if (lat == 0) cin_first = 1;
         end
         @(posedge clk); #1;
         lat++;
      end
      check("done_timeout", out_valid, 1);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("take_valid_drop", out_valid, 0);
      check("take_in_ready", in_ready, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
      #1;
      check("drain_empty", exp_q.size(), 0);
   endtask

   int lat, clr_lo, cin_hi, cin_first;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_adder_clr", adder_clr, 1);
      check("rst_serial", {a_bit, b_bit, cin_bit}, 0);
      check("rst_sum", {cout, sum}, 0);
      clr = 1'b1;
      @(posedge clk); #1;

      // basic word, latency and clear window
      send_word(8'h0B, 8'h0D, 1'b0, 1'b0);
      measure(lat, clr_lo, cin_hi, cin_first);
      check("lat_0b0d", lat, 9);
      check("clr_low_0b0d", clr_lo, 9);
      check("cin_hi_0b0d", cin_hi, 0);
      check("sum_0b0d", {cout, sum}, 9'h018);
      take();

      send_word(8'hFF, 8'h01, 1'b0, 1'b0);
      measure(lat, clr_lo, cin_hi, cin_first);
      check("sum_ff01", {cout, sum}, 9'h100);
      take();

      send_word(8'h00, 8'h00, 1'b1, 1'b0);
      measure(lat, clr_lo, cin_hi, cin_first);
      check("cin_hi_count", cin_hi, 1);
      check("cin_first", cin_first, 1);
      check("sum_0001", {cout, sum}, 9'h001);
      check("sum_hold_pre", sum, 8'h01);
      take();
      check("sum_hold_post", sum, 8'h01);

      // backpressure with a pending word
      send_word(8'h30, 8'h41, 1'b1, 1'b0);
      measure(lat, clr_lo, cin_hi, cin_first);
      op_a = 8'h12; op_b = 8'h34; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", out_valid, 1);
         check("bp_sum", {cout, sum}, 9'h072);
         check("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_rel_in_ready", in_ready, 1);
      check("bp_rel_valid", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_second_accept", adder_clr, 0);
      measure(lat, clr_lo, cin_hi, cin_first);
      check("lat_second", lat, 9);
      check("sum_1234", {cout, sum}, 9'h046);
      take();

      // reset during SHIFT bit 3
      send_word(8'h0F, 8'h01, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_shift", state, SHIFT);
      clr = 1'b0;
      #1;
      exp_q.delete();
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_adder_clr", adder_clr, 1);
      check("mid_rst_a_bit", a_bit, 0);
      check("mid_rst_sum", {cout, sum}, 0);
      @(posedge clk); #1;
      clr = 1'b1;
      send_word(8'h55, 8'hAA, 1'b0, 1'b0);
      measure(lat, clr_lo, cin_hi, cin_first);
      check("sum_55aa", {cout, sum}, 9'h0FF);
      take();
      check("no_stale_result", exp_q.size(), 0);

      // back-to-back with both handshakes held open
      out_t.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++)
         send_word(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), (i < 3) ? 1'b1 : 1'b0);
      drain();
      out_ready = 1'b0;
      check("b2b_count", out_t.size(), 4);
      if (out_t.size() == 4)
         for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(out_t[i] - out_t[i-1]), 110);

      // random regression with stalls on both sides
      begin
         int start_out;
         start_out = n_out;
         fork
            begin
               for (int i = 0; i < 1000; i++) begin
                  repeat ($urandom_range(0, 3)) @(posedge clk);
                  #1;
                  send_word(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
               end
            end
            begin
               for (int g = 0; g < 60000 && (n_out - start_out) < 1000; g++) begin
                  @(posedge clk); #1;
                  out_ready = 1'($urandom_range(0, 1));
               end
               out_ready = 1'b0;
            end
         join
         check("rand_count", n_out - start_out, 1000);
         check("rand_q_empty", exp_q.size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Word-level front end for the bit-serial adder; it drives the adder's side of the serial interface.
- Accepts two parallel WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Shifts the operands LSB-first into an external serial adder, collects the returned sum bits, and captures the final carry.
- Presents the parallel result over a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand/sum width in bits (>=2).
- CW, $clog2(WIDTH), bit-counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- clr  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand word valid.
- in_ready  out  1  block can accept an operand word.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- cin  in  1  carry-in for the word.
- a_bit  out  1  serial A bit to the adder.
- b_bit  out  1  serial B bit to the adder.
- cin_bit  out  1  serial carry-in to the adder.
- adder_clr  out  1  active-high clear of the adder's carry register.
- s_bit  in  1  adder sum bit; combinational in a_bit/b_bit/cin_bit/adder carry.
- c_bit  in  1  adder's registered carry.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result word.
- cout  out  1  carry out of the MSB.

Behaviour:
- Reset (clr low, async):
  - State goes to IDLE; bit counter, operand, sum and cout registers go to 0.
  - Outputs: out_valid=0, sum=0, cout=0, a_bit=b_bit=cin_bit=0, adder_clr=1, in_ready=1.
  - in_valid is ignored while clr is low.
  - Reset mid-operation aborts the word; no partial result is ever presented.
- FSM states: IDLE, SHIFT, CARRY, DONE.
- IDLE:
  - in_ready=1, adder_clr=1, serial outputs 0.
  - On in_valid&in_ready: capture op_a, op_b, cin; cnt=0; go to SHIFT.
- SHIFT:
  - adder_clr=0; a_bit=areg[0], b_bit=breg[0].
  - cin_bit = cin_r when cnt==0, else 0.
  - Each edge: areg and breg shift right, sreg shifts right with s_bit inserted at the MSB, cnt increments.
  - At cnt==WIDTH-1, go to CARRY.
  - Each SHIFT cycle lasts exactly one clock, WIDTH cycles total.
- CARRY:
  - adder_clr=0, serial outputs 0.
  - c_bit now holds the MSB carry-out; capture it into cout; go to DONE.
- DONE:
  - out_valid=1; sum=sreg; cout held; adder_clr=1; in_ready=0.
  - sum/cout must stay stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE; out_valid drops on the next edge.
- Latency: out_valid rises WIDTH+1 edges after the accept edge.
- Throughput: with in_valid and out_ready held high, one word per WIDTH+3 cycles.
- No overlap: a new word is never accepted while a word is in flight.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1).
- sum holds its last value after the handshake until the next DONE.
- in_valid high in any state other than IDLE has no effect.
- Simultaneous out_ready and new in_valid in DONE: only the out handshake completes; the input is accepted in the following IDLE cycle.

Decomposition:
- Shared package serial_add_pkg holds:
  - state typedef {IDLE, SHIFT, CARRY, DONE};
  - default WIDTH constant;
  - a localparam for the reset value of adder_clr.
- No sub-module is required. The three shift registers and the counter are in-line.
- The bench pairs this block with the existing serial adder, or with a behavioral model honoring the s_bit/c_bit contract above.

Test Plan:
- WIDTH=8, op_a=0x0B, op_b=0x0D, cin=0 -> sum=0x18, cout=0; out_valid exactly 9 edges after accept; adder_clr low for exactly 9 cycles.
- 0xFF+0x01, cin=0 -> sum=0x00, cout=1. Then 0x00+0x00, cin=1 -> sum=0x01, cout=0; cin_bit high only in the first SHIFT cycle.
- Backpressure: out_ready held low for 5 cycles in DONE with in_valid high -> out_valid=1, sum/cout unchanged, in_ready=0, no second accept. Release -> in_ready=1 one edge later, and the second word is accepted.
- Reset pulse asserted during SHIFT bit 3 -> immediately out_valid=0, in_ready=1, adder_clr=1, a_bit=0. Next word 0x55+0xAA, cin=0 -> sum=0xFF, cout=0.
- Back-to-back: in_valid and out_ready high, 4 random words -> results match the reference sum in order, spaced 11 cycles apart.
- Random regression: 1000 words with random stalls on both handshakes, checked against op_a+op_b+cin.
